// File: rtl/clz_seq_ctrl.sv
// Iterative count-leading-zeros / floor(log2) sequencer: one shared halving step
// runs STAGES times over a working register, with a valid/ready handshake on each side.
module clz_seq_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int RES_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enb,
    input  logic                  i_VALID,
    output logic                  o_READY,
    input  logic [DATA_WIDTH-1:0] i_WORD,
    output logic                  o_VALID,
    input  logic                  i_READY,
    output logic [RES_WIDTH-1:0]  o_RESULT,
    output logic [RES_WIDTH-1:0]  o_LOG2,
    output logic                  o_ZERO,
    output logic [DATA_WIDTH-1:0] o_NORM
);

    localparam int STAGES = $clog2(DATA_WIDTH);
    localparam int AW     = STAGES + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            r_state;
    logic [DATA_WIDTH-1:0] r_wreg;
    logic [AW-1:0]         r_acc;
    logic [AW-1:0]         r_cnt;
    logic [RES_WIDTH-1:0]  r_result;
    logic [RES_WIDTH-1:0]  r_log2;
    logic                  r_zero;
    logic [DATA_WIDTH-1:0] r_norm;

    logic [AW-1:0]         w_shift;
    logic [AW-1:0]         w_top_sh;
    logic                  w_top_zero;
    logic [DATA_WIDTH-1:0] w_wreg_step;
    logic [AW-1:0]         w_acc_step;
    logic                  w_last;
    logic                  w_zero_fin;
    logic [AW-1:0]         w_acc_fin;
    logic [RES_WIDTH-1:0]  w_log2_fin;

    // Step cnt inspects the top s = DATA_WIDTH>>(cnt+1) bits of the live window.
    assign w_shift     = AW'(DATA_WIDTH >> (r_cnt + AW'(1)));
    assign w_top_sh    = AW'(DATA_WIDTH) - w_shift;
    assign w_top_zero  = (r_wreg >> w_top_sh) == '0;
    assign w_wreg_step = w_top_zero ? (r_wreg << w_shift) : r_wreg;
    assign w_acc_step  = w_top_zero ? (r_acc | w_shift) : r_acc;
    assign w_last      = (r_cnt == AW'(STAGES - 1));

    // After the final 1-bit step only a zero operand can still have a clear MSB.
    assign w_zero_fin  = ~w_wreg_step[DATA_WIDTH-1];
    assign w_acc_fin   = w_acc_step + AW'(w_zero_fin);
    assign w_log2_fin  = w_zero_fin ? '0 : RES_WIDTH'(DATA_WIDTH - 1) - RES_WIDTH'(w_acc_fin);

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values of the step logic, matching the hardware it describes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_wreg   <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_log2   <= '0;
            r_zero   <= 1'b0;
            r_norm   <= '0;
        end else if (enb) begin
            case (r_state)
                S_IDLE: begin
                    if (i_VALID) begin
                        r_wreg  <= i_WORD;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_wreg <= w_wreg_step;
                    r_cnt  <= r_cnt + AW'(1);
                    if (w_last) begin
                        r_acc    <= w_acc_fin;
                        r_result <= RES_WIDTH'(w_acc_fin);
                        r_log2   <= w_log2_fin;
                        r_zero   <= w_zero_fin;
                        r_norm   <= w_wreg_step;
                        r_state  <= S_DONE;
                    end else begin
                        r_acc <= w_acc_step;
                    end
                end
                S_DONE: begin
                    if (i_READY) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_READY  = reset && (r_state == S_IDLE);
    assign o_VALID  = (r_state == S_DONE);
    assign o_RESULT = r_result;
    assign o_LOG2   = r_log2;
    assign o_ZERO   = r_zero;
    assign o_NORM   = r_norm;

endmodule
